// File: rtl/up_pkg.sv
// Shared types and constants for the up_fetch instruction fetch stage.
package up_pkg;

  localparam int UP_ADDR_W = 8;
  localparam int UP_DATA_W = 8;
  localparam logic [UP_ADDR_W-1:0] UP_RESET_PC = 8'h00;

  typedef enum logic [1:0] {
    FETCH,
    STALL,
    HALTED
  } fetch_state_e;

  typedef struct packed {
    logic [UP_DATA_W-1:0] data;
    logic [UP_ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/up_fetch_if.sv
// Memory read port and decoder handshake of the fetch stage, grouped as one bundle.
interface up_fetch_if
  import up_pkg::*;
#(
  parameter int ADDR_W = UP_ADDR_W,
  parameter int DATA_W = UP_DATA_W
);

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_re;
  logic              jump;
  logic [ADDR_W-1:0] jump_addr;
  logic              halt;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              halted;

  // master is the fetch stage, slave is the memory/decoder/core side
  modport master (
    output mem_addr, instr, instr_pc, instr_valid, halted,
    input  mem_data, mem_re, jump, jump_addr, halt, instr_ready
  );

  modport slave (
    input  mem_addr, instr, instr_pc, instr_valid, halted,
    output mem_data, mem_re, jump, jump_addr, halt, instr_ready
  );

endinterface

// File: rtl/up_fetch_fifo.sv
// Small synchronous prefetch FIFO of fetch entries; flush wins over push and pop.
module up_fetch_fifo
  import up_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t rd_entry,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  slots [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // when full, a push is only accepted together with a pop freeing the head slot
  assign do_push  = push && (!full || do_pop);
  assign rd_entry = slots[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        slots[wr_ptr] <= wr_entry;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/up_fetch.sv
// Instruction fetch stage: drives memory address, prefetches into a FIFO, hands entries to the decoder.
// Optional same-cycle bypass of an empty FIFO is enabled by defining UP_FETCH_BYPASS_EN.
module up_fetch
  import up_pkg::*;
#(
  parameter int                ADDR_W   = UP_ADDR_W,
  parameter int                DATA_W   = UP_DATA_W,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = UP_RESET_PC
) (
  input logic        clk,
  input logic        rst,
  up_fetch_if.master bus
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [DATA_W-1:0] mem_word;
  fetch_entry_t      new_entry;
  fetch_entry_t      head;
  fetch_entry_t      held;
  fetch_entry_t      shown;
  logic              show_valid;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic              take;
  logic              can_fetch;
  logic              consume_direct;

  assign mem_word  = bus.mem_data;
  assign new_entry = '{data: mem_word, pc: fetch_pc};

`ifdef UP_FETCH_BYPASS_EN
  logic bypass;
  assign bypass         = fifo_empty && (state == FETCH) && bus.mem_re && !bus.jump && !bus.halt;
  assign consume_direct = bypass && bus.instr_ready;
`else
  assign consume_direct = 1'b0;
`endif

  // an empty FIFO keeps showing whatever the decoder last saw
  always_comb begin
    shown      = held;
    show_valid = 1'b0;
    if (!fifo_empty) begin
      shown      = head;
      show_valid = 1'b1;
    end
`ifdef UP_FETCH_BYPASS_EN
    else if (bypass) begin
      shown      = new_entry;
      show_valid = 1'b1;
    end
`endif
  end

  assign take      = show_valid && bus.instr_ready;
  assign fifo_pop  = take && !fifo_empty;
  assign can_fetch = !bus.jump && !bus.halt && bus.mem_re && (!fifo_full || fifo_pop);
  assign fifo_push = can_fetch && !consume_direct;

  up_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .flush    (bus.jump),
    .wr_entry (new_entry),
    .rd_entry (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // jump and halt may coincide: the redirect lands and the state still goes to HALTED
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      held     <= '0;
    end else begin
      held <= shown;
      if (bus.jump) begin
        fetch_pc <= bus.jump_addr;
      end else if (can_fetch) begin
        fetch_pc <= fetch_pc + ADDR_W'(1);
      end
      if (bus.halt) begin
        state <= HALTED;
      end else if (bus.jump || can_fetch || state == HALTED) begin
        state <= FETCH;
      end else begin
        state <= STALL;
      end
    end
  end

  assign bus.mem_addr    = fetch_pc;
  assign bus.instr       = shown.data;
  assign bus.instr_pc    = shown.pc;
  assign bus.instr_valid = show_valid;
  assign bus.halted      = (state == HALTED);

endmodule

// File: tb/tb_up_fetch.sv
// Randomised self-checking bench for up_fetch against a queue-based model of the fetch rules.
module tb_up_fetch;
  import up_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  up_fetch_if bus ();

  up_fetch #(
    .DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [256];
  assign bus.mem_data = mem[bus.mem_addr];

  int checks = 0;
  int fails  = 0;

  fetch_entry_t q[$];
  fetch_entry_t delivered[$];
  fetch_entry_t m_held;
  logic [7:0]   m_pc;
  bit           m_halted;
  bit           m_fetching;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // one clock cycle: drive inputs, compare outputs with the model, then advance the model
  task automatic applyStimulus(input bit r, input bit j, input logic [7:0] ja,
                               input bit h, input bit rdy, input bit re);
    bit           bp;
    bit           exp_valid;
    bit           took;
    bit           fetch;
    int           sz;
    fetch_entry_t exp_e;
    @(negedge clk);
    rst            = r;
    bus.jump       = j;
    bus.jump_addr  = ja;
    bus.halt       = h;
    bus.instr_ready = rdy;
    bus.mem_re     = re;
    #1;
    bp = 1'b0;
`ifdef UP_FETCH_BYPASS_EN
    bp = (q.size() == 0) && m_fetching && !m_halted && re && !j && !h;
`endif
    exp_valid = (q.size() > 0) || bp;
    if (q.size() > 0) exp_e = q[0];
    else if (bp)      exp_e = fetch_entry_t'({mem[m_pc], m_pc});
    else              exp_e = m_held;
    checkOutput("instr_valid", 32'(bus.instr_valid), 32'(exp_valid));
    checkOutput("instr", 32'(bus.instr), 32'(exp_e.data));
    checkOutput("instr_pc", 32'(bus.instr_pc), 32'(exp_e.pc));
    checkOutput("mem_addr", 32'(bus.mem_addr), 32'(m_pc));
    checkOutput("halted", 32'(bus.halted), 32'(m_halted));
    if (bus.instr_valid && rdy) delivered.push_back(fetch_entry_t'({bus.instr, bus.instr_pc}));
    if (r) begin
      q.delete();
      m_pc       = UP_RESET_PC;
      m_held     = '0;
      m_halted   = 1'b0;
      m_fetching = 1'b1;
    end else begin
      took   = exp_valid && rdy;
      fetch  = 1'b0;
      m_held = exp_e;
      if (j) begin
        q.delete();
        m_pc = ja;
      end else begin
        sz = q.size();
        if (took && sz > 0) void'(q.pop_front());
        fetch = !h && re && (sz < DEPTH || (took && sz > 0));
        if (fetch) begin
          if (!(bp && rdy)) q.push_back(fetch_entry_t'({mem[m_pc], m_pc}));
          m_pc++;
        end
      end
      if (h) begin
        m_halted   = 1'b1;
        m_fetching = 1'b0;
      end else if (j || m_halted || fetch) begin
        m_halted   = 1'b0;
        m_fetching = 1'b1;
      end else begin
        m_fetching = 1'b0;
      end
    end
  endtask

  task automatic checkSeq(input string tag, input logic [7:0] pcs[4], input int n);
    checkOutput({tag, "_count"}, 32'(delivered.size() >= n), 32'd1);
    for (int i = 0; i < n && i < delivered.size(); i++) begin
      checkOutput({tag, "_pc"}, 32'(delivered[i].pc), 32'(pcs[i]));
      checkOutput({tag, "_data"}, 32'(delivered[i].data), 32'(mem[pcs[i]]));
    end
  endtask

  initial begin
    logic [7:0] pcs[4];
    bit         halt_lvl;
    bus.jump        = 1'b0;
    bus.jump_addr   = '0;
    bus.halt        = 1'b0;
    bus.instr_ready = 1'b0;
    bus.mem_re      = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hC6;
    mem[1] = 8'hC5;
    mem[2] = 8'h6C;
    q.delete();
    m_pc = UP_RESET_PC; m_held = '0; m_halted = 1'b0; m_fetching = 1'b1;

    // reset, then free-running fetch with the decoder always ready
    applyStimulus(1, 0, 8'h00, 0, 1, 1);
    applyStimulus(1, 0, 8'h00, 0, 1, 1);
    delivered.delete();
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 8'h00, 0, 1, 1);
    pcs = '{8'h00, 8'h01, 8'h02, 8'h03};
    checkSeq("stream", pcs, 3);

    // decoder back-pressure fills the FIFO, then drains without gaps or repeats
    applyStimulus(1, 0, 8'h00, 0, 0, 1);
    delivered.delete();
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 8'h00, 0, 0, 1);
    checkOutput("fill_addr", 32'(bus.mem_addr), 32'h02);
    checkOutput("fill_head", 32'(bus.instr), 32'hC6);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 8'h00, 0, 1, 1);
    checkSeq("drain", pcs, 3);

    // jump with a full FIFO: flush, then the target arrives first
    applyStimulus(1, 0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 8'h00, 0, 0, 1);
    applyStimulus(0, 1, 8'h0A, 0, 0, 1);
    delivered.delete();
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 8'h00, 0, 1, 1);
    pcs = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
    checkSeq("jump", pcs, 2);

    // PC wrap after a jump near the top of memory
    applyStimulus(0, 1, 8'hFE, 0, 1, 1);
    delivered.delete();
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 8'h00, 0, 1, 1);
    pcs = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    checkSeq("wrap", pcs, 4);

    // halt with two entries queued: both drain, nothing new fetched
    applyStimulus(1, 0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 8'h00, 0, 0, 1);
    delivered.delete();
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 8'h00, 1, 1, 1);
    checkOutput("halt_flag", 32'(bus.halted), 32'd1);
    checkOutput("halt_drain", 32'(delivered.size()), 32'd2);
    checkOutput("halt_addr", 32'(bus.mem_addr), 32'h02);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 8'h00, 0, 1, 1);

    // reset in the middle of a stalled handshake
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 8'h00, 0, 0, 1);
    applyStimulus(1, 0, 8'h00, 0, 0, 1);
    applyStimulus(0, 0, 8'h00, 0, 0, 0);
    checkOutput("rst_addr", 32'(bus.mem_addr), 32'(UP_RESET_PC));
`ifndef UP_FETCH_BYPASS_EN
    checkOutput("rst_valid", 32'(bus.instr_valid), 32'd0);
`endif

    // randomised traffic
    halt_lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) halt_lvl = ~halt_lvl;
      applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 19) == 0,
                    8'($urandom_range(0, 255)), halt_lvl,
                    $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
